// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : apb_pkg
// Brief   : Shared APB phase encoding and default geometry for apb_mem_slave.
// Revision: 1.0
// ============================================================================
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int C_DATA_WIDTH = 32;
    localparam int C_ADDR_WIDTH = 32;
    localparam int C_MEM_DEPTH  = 32;

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_mem_slave_if.sv
`default_nettype none
// ============================================================================
// Module  : apb_mem_slave_if
// Brief   : APB bus bundle with master/slave views.
// Revision: 1.0
// ============================================================================
interface apb_mem_slave_if
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = C_ADDR_WIDTH,
    parameter int DATA_WIDTH = C_DATA_WIDTH
);
    logic [ADDR_WIDTH-1:0] P_addr;
    logic                  P_selx;
    logic                  P_enable;
    logic                  P_write;
    logic [DATA_WIDTH-1:0] P_wdata;
    logic                  P_ready;
    logic                  P_slverr;
    logic [DATA_WIDTH-1:0] P_rdata;

    modport master (
        output P_addr, P_selx, P_enable, P_write, P_wdata,
        input  P_ready, P_slverr, P_rdata
    );

    modport slave (
        input  P_addr, P_selx, P_enable, P_write, P_wdata,
        output P_ready, P_slverr, P_rdata
    );

endinterface : apb_mem_slave_if
`default_nettype wire

// File: rtl/apb_mem_array.sv
`default_nettype none
// ============================================================================
// Module  : apb_mem_array
// Brief   : MEM_DEPTH x DATA_WIDTH register memory, sync write, registered read.
// Revision: 1.0
// ============================================================================
module apb_mem_array
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int MEM_DEPTH  = C_MEM_DEPTH,
    parameter int IDX_W      = $clog2(MEM_DEPTH)
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_wr_en,
    input  wire logic                  i_rd_en,
    input  wire logic                  i_rd_zero,
    input  wire logic [IDX_W-1:0]      i_idx,
    input  wire logic [DATA_WIDTH-1:0] i_wdata,
    output      logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata_q;
    logic [DATA_WIDTH-1:0] w_rdata_d;

    // Read data only moves on a read commit; an out-of-range read returns zero.
    always_comb begin
        w_rdata_d = r_rdata_q;
        if (i_rd_en) begin
            w_rdata_d = i_rd_zero ? '0 : r_mem_q[i_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem_q[i] <= '0;
            end
            r_rdata_q <= '0;
        end else begin
            if (i_wr_en) begin
                r_mem_q[i_idx] <= i_wdata;
            end
            r_rdata_q <= w_rdata_d;
        end
    end

    assign o_rdata = r_rdata_q;

endmodule : apb_mem_array
`default_nettype wire

// File: rtl/apb_mem_slave.sv
`default_nettype none
// ============================================================================
// Module  : apb_mem_slave
// Brief   : Zero-wait-state APB slave with phase-tracking FSM over a word memory.
// Revision: 1.0
// ============================================================================
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int ADDR_WIDTH = C_ADDR_WIDTH,
    parameter int MEM_DEPTH  = C_MEM_DEPTH
) (
    input wire logic         P_clk,
    input wire logic         P_rst,
    apb_mem_slave_if.slave   bus
);

    localparam int                    C_IDX_W    = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] C_DEPTH    = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [1:0]            C_ST_IDLE   = IDLE;
    localparam logic [1:0]            C_ST_SETUP  = SETUP;
    localparam logic [1:0]            C_ST_ACCESS = ACCESS;

    logic [1:0] r_state_q;
    logic [1:0] w_state_d;
    logic       w_setup;
    logic       w_access;
    logic       w_valid;
    logic       w_oor;

    assign w_setup  = bus.P_selx & ~bus.P_enable;
    assign w_access = bus.P_selx &  bus.P_enable;
    // Only an ACCESS immediately after SETUP is a transfer; a held P_enable
    // leaves the state in ACCESS so it can never complete twice.
    assign w_valid  = w_access & (r_state_q == C_ST_SETUP) & ~P_rst;
    assign w_oor    = (bus.P_addr >= C_DEPTH);

    always_comb begin
        w_state_d = C_ST_IDLE;
        if (w_setup) begin
            w_state_d = C_ST_SETUP;
        end else if (w_access) begin
            w_state_d = C_ST_ACCESS;
        end
    end

    always_ff @(posedge P_clk) begin
        if (P_rst) begin
            r_state_q <= C_ST_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    assign bus.P_ready  = w_valid;
    assign bus.P_slverr = w_valid & w_oor;

    apb_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .IDX_W      (C_IDX_W)
    ) u_mem (
        .clk       (P_clk),
        .rst       (P_rst),
        .i_wr_en   (w_valid &  bus.P_write & ~w_oor),
        .i_rd_en   (w_valid & ~bus.P_write),
        .i_rd_zero (w_oor),
        .i_idx     (bus.P_addr[C_IDX_W-1:0]),
        .i_wdata   (bus.P_wdata),
        .o_rdata   (bus.P_rdata)
    );

endmodule : apb_mem_slave
`default_nettype wire

// File: tb/tb_apb_mem_slave.sv
`default_nettype none
// ============================================================================
// Module  : tb_apb_mem_slave
// Brief   : Directed self-checking bench for apb_mem_slave.
// Revision: 1.0
// ============================================================================
module tb_apb_mem_slave;

    logic P_clk = 1'b0;
    logic P_rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 P_clk = ~P_clk;

    apb_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_mem_slave #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .MEM_DEPTH  (32)
    ) dut (
        .P_clk (P_clk),
        .P_rst (P_rst),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One SETUP+ACCESS transfer; the address may change between phases and
    // P_enable may optionally be held one extra cycle.
    task automatic xfer(input string tag, input logic wr, input logic [31:0] a_setup,
                        input logic [31:0] a_access, input logic [31:0] wd,
                        input logic exp_err, input logic hold_en);
        @(posedge P_clk); #1;
        bus.P_selx   = 1'b1;
        bus.P_enable = 1'b0;
        bus.P_write  = wr;
        bus.P_addr   = a_setup;
        bus.P_wdata  = 32'hDEAD_BEEF;
        #1;
        check({tag, "_setup_ready"}, {31'd0, bus.P_ready}, 32'd0);
        @(posedge P_clk); #1;
        bus.P_enable = 1'b1;
        bus.P_addr   = a_access;
        bus.P_wdata  = wd;
        #1;
        check({tag, "_access_ready"},  {31'd0, bus.P_ready},  32'd1);
        check({tag, "_access_slverr"}, {31'd0, bus.P_slverr}, {31'd0, exp_err});
        if (hold_en) begin
            @(posedge P_clk); #1;
            check({tag, "_held_ready"}, {31'd0, bus.P_ready}, 32'd0);
        end
        @(posedge P_clk); #1;
        bus.P_selx   = 1'b0;
        bus.P_enable = 1'b0;
        #1;
        check({tag, "_idle_ready"}, {31'd0, bus.P_ready}, 32'd0);
    endtask

    initial begin
        bus.P_selx   = 1'b0;
        bus.P_enable = 1'b0;
        bus.P_write  = 1'b0;
        bus.P_addr   = '0;
        bus.P_wdata  = '0;

        // Reset: outputs low even with an access presented
        @(posedge P_clk); #1;
        bus.P_selx   = 1'b1;
        bus.P_enable = 1'b1;
        #1;
        check("rst_ready",  {31'd0, bus.P_ready},  32'd0);
        check("rst_slverr", {31'd0, bus.P_slverr}, 32'd0);
        check("rst_rdata",  bus.P_rdata,           32'd0);
        @(posedge P_clk); #1;
        bus.P_selx   = 1'b0;
        bus.P_enable = 1'b0;
        P_rst        = 1'b0;

        xfer("rd0", 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        check("rd0_data", bus.P_rdata, 32'd0);
        xfer("rd31", 1'b0, 32'd31, 32'd31, 32'd0, 1'b0, 1'b0);
        check("rd31_data", bus.P_rdata, 32'd0);

        // Write / readback
        xfer("wr1", 1'b1, 32'd1, 32'd1, 32'd7, 1'b0, 1'b0);
        xfer("wr2", 1'b1, 32'd2, 32'd2, 32'd3, 1'b0, 1'b0);
        xfer("rd1", 1'b0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0);
        check("rd1_data", bus.P_rdata, 32'd7);
        xfer("rd2", 1'b0, 32'd2, 32'd2, 32'd0, 1'b0, 1'b0);
        check("rd2_data", bus.P_rdata, 32'd3);
        xfer("rd3", 1'b0, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0);
        check("rd3_data", bus.P_rdata, 32'd0);

        // ACCESS-phase address wins over SETUP-phase address
        xfer("rdchg", 1'b0, 32'd0, 32'd1, 32'd0, 1'b0, 1'b0);
        check("rdchg_data", bus.P_rdata, 32'd7);

        // Out of range: error, no alias to word 8, read returns zero
        xfer("wr40", 1'b1, 32'd40, 32'd40, 32'd5, 1'b1, 1'b0);
        check("wr40_rdata_hold", bus.P_rdata, 32'd7);
        xfer("rd40", 1'b0, 32'd40, 32'd40, 32'd0, 1'b1, 1'b0);
        check("rd40_data", bus.P_rdata, 32'd0);
        xfer("rd8", 1'b0, 32'd8, 32'd8, 32'd0, 1'b0, 1'b0);
        check("rd8_data", bus.P_rdata, 32'd0);
        xfer("rdhi", 1'b0, 32'h8000_0001, 32'h8000_0001, 32'd0, 1'b1, 1'b0);

        // Access without setup: two cycles, never ready
        @(posedge P_clk); #1;
        bus.P_selx   = 1'b1;
        bus.P_enable = 1'b1;
        bus.P_write  = 1'b1;
        bus.P_addr   = 32'd4;
        bus.P_wdata  = 32'd9;
        #1;
        check("nosetup_ready0", {31'd0, bus.P_ready}, 32'd0);
        @(posedge P_clk); #1;
        check("nosetup_ready1", {31'd0, bus.P_ready}, 32'd0);
        @(posedge P_clk); #1;
        bus.P_selx   = 1'b0;
        bus.P_enable = 1'b0;

        // Enable held past one cycle: single commit only
        xfer("wr6hold", 1'b1, 32'd6, 32'd6, 32'd11, 1'b0, 1'b1);
        xfer("rd6", 1'b0, 32'd6, 32'd6, 32'd0, 1'b0, 1'b0);
        check("rd6_data", bus.P_rdata, 32'd11);
        xfer("wr7", 1'b1, 32'd7, 32'd7, 32'd13, 1'b0, 1'b0);
        check("wr7_rdata_hold", bus.P_rdata, 32'd11);
        xfer("rd4", 1'b0, 32'd4, 32'd4, 32'd0, 1'b0, 1'b0);
        check("rd4_data", bus.P_rdata, 32'd0);
        xfer("rd7", 1'b0, 32'd7, 32'd7, 32'd0, 1'b0, 1'b0);
        check("rd7_data", bus.P_rdata, 32'd13);

        // Reset during the ACCESS of a write
        @(posedge P_clk); #1;
        bus.P_selx   = 1'b1;
        bus.P_enable = 1'b0;
        bus.P_write  = 1'b1;
        bus.P_addr   = 32'd5;
        bus.P_wdata  = 32'd6;
        @(posedge P_clk); #1;
        bus.P_enable = 1'b1;
        P_rst        = 1'b1;
        #1;
        check("rstmid_ready",  {31'd0, bus.P_ready},  32'd0);
        check("rstmid_slverr", {31'd0, bus.P_slverr}, 32'd0);
        @(posedge P_clk); #1;
        check("rstmid_rdata", bus.P_rdata, 32'd0);
        bus.P_selx   = 1'b0;
        bus.P_enable = 1'b0;
        P_rst        = 1'b0;
        xfer("rd5", 1'b0, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0);
        check("rd5_data", bus.P_rdata, 32'd0);
        xfer("rd7clr", 1'b0, 32'd7, 32'd7, 32'd0, 1'b0, 1'b0);
        check("rd7clr_data", bus.P_rdata, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_apb_mem_slave
`default_nettype wire
